// File: rtl/softplus_sequencer_pkg.sv
// Shared constants, state encoding and IEEE-754 single round/pack helper
// for the softplus sequencer and its float units.
package softplus_sequencer_pkg;

    localparam logic [31:0] LN2       = 32'h3F317218;
    localparam logic [31:0] NEG_192   = 32'hC3400000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC00000;
    localparam int          CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL2 = 3'd1,
        S_MUL4 = 3'd2,
        S_DIV  = 3'd3,
        S_ADD1 = 3'd4,
        S_ADD2 = 3'd5,
        S_ADD3 = 3'd6,
        S_DONE = 3'd7
    } state_e;

    // sig carries the hidden bit at [23]; value = sig * 2^(e-150).
    // Round-to-nearest-even, overflow to Inf, underflow flushed to signed zero.
    function automatic logic [31:0] fp_round_pack(input logic s, input int e,
                                                  input logic [23:0] sig,
                                                  input logic g, input logic st);
        logic [24:0] r;
        int          ee;
        r  = {1'b0, sig} + 25'(g & (st | sig[0]));
        ee = e;
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) return {s, 8'hFF, 23'd0};
        if (ee <= 0)   return {s, 31'd0};
        return {s, ee[7:0], r[22:0]};
    endfunction

endpackage

// File: rtl/FloatingAddition.sv
// Combinational single-precision add, round-to-nearest-even,
// denormal inputs treated as zero.
module FloatingAddition
    import softplus_sequencer_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] big, sml;
    logic [26:0] sig_b, sig_s, sig_n;
    logic [27:0] sum;
    logic        sticky;
    int          d, e;

    assign a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    assign b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
    assign a_zero = (a_i[30:23] == 8'h00);
    assign b_zero = (b_i[30:23] == 8'h00);

    always_comb begin
        big    = a_i;
        sml    = b_i;
        sig_b  = '0;
        sig_s  = '0;
        sig_n  = '0;
        sum    = '0;
        sticky = 1'b0;
        d      = 0;
        e      = 0;
        y_o    = '0;
        if (a_i[30:0] < b_i[30:0]) begin
            big = b_i;
            sml = a_i;
        end
        if (a_nan || b_nan) begin
            y_o = FP_QNAN;
        end else if (a_inf && b_inf) begin
            y_o = (a_i[31] == b_i[31]) ? a_i : FP_QNAN;
        end else if (a_inf) begin
            y_o = a_i;
        end else if (b_inf) begin
            y_o = b_i;
        end else if (a_zero && b_zero) begin
            y_o = {a_i[31] & b_i[31], 31'd0};
        end else if (a_zero) begin
            y_o = b_i;
        end else if (b_zero) begin
            y_o = a_i;
        end else begin
            // Three extra low bits (guard, round, sticky) keep rounding exact.
            d     = int'(big[30:23]) - int'(sml[30:23]);
            sig_b = {1'b1, big[22:0], 3'b000};
            sig_s = {1'b1, sml[22:0], 3'b000};
            if (d >= 27) begin
                sig_s = 27'd1;
            end else if (d > 0) begin
                sticky = |(sig_s & ((27'd1 << d) - 27'd1));
                sig_s  = (sig_s >> d) | {26'd0, sticky};
            end
            e = int'(big[30:23]);
            if (big[31] == sml[31])
                sum = {1'b0, sig_b} + {1'b0, sig_s};
            else
                sum = {1'b0, sig_b} - {1'b0, sig_s};
            if (sum[27]) begin
                sig_n = sum[27:1] | {26'd0, sum[0]};
                e     = e + 1;
            end else begin
                sig_n = sum[26:0];
                for (int i = 0; i < 27; i++) begin
                    if (!sig_n[26] && (sig_n != '0)) begin
                        sig_n = sig_n << 1;
                        e     = e - 1;
                    end
                end
            end
            if (sig_n == '0)
                y_o = 32'd0;
            else
                y_o = fp_round_pack(big[31], e, sig_n[26:3], sig_n[2], |sig_n[1:0]);
        end
    end

endmodule

// File: rtl/FloatingDivision.sv
// Combinational single-precision divide, round-to-nearest-even,
// denormal inputs treated as zero.
module FloatingDivision
    import softplus_sequencer_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [49:0] num, den;
    logic [26:0] quo;
    logic [23:0] rem;
    int          e;

    assign a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    assign b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
    assign a_zero = (a_i[30:23] == 8'h00);
    assign b_zero = (b_i[30:23] == 8'h00);

    always_comb begin
        s   = a_i[31] ^ b_i[31];
        num = '0;
        den = '0;
        quo = '0;
        rem = '0;
        e   = 0;
        y_o = '0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            y_o = FP_QNAN;
        end else if (a_inf || b_zero) begin
            y_o = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            y_o = {s, 31'd0};
        end else begin
            // Quotient of the significands carries 26 fraction bits below the
            // leading one so guard/round/sticky are exact.
            num = {1'b1, a_i[22:0], 26'd0};
            den = {26'd0, 1'b1, b_i[22:0]};
            quo = 27'(num / den);
            rem = 24'(num % den);
            e   = int'(a_i[30:23]) - int'(b_i[30:23]) + 127;
            if (quo[26])
                y_o = fp_round_pack(s, e, quo[26:3], quo[2], (|quo[1:0]) | (rem != '0));
            else
                y_o = fp_round_pack(s, e - 1, quo[25:2], quo[1], quo[0] | (rem != '0));
        end
    end

endmodule

// File: rtl/FloatingMultiplication.sv
// Combinational single-precision multiply, round-to-nearest-even,
// denormal inputs treated as zero.
module FloatingMultiplication
    import softplus_sequencer_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        s;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    int          e;

    assign a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
    assign b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
    assign a_zero = (a_i[30:23] == 8'h00);
    assign b_zero = (b_i[30:23] == 8'h00);

    always_comb begin
        s    = a_i[31] ^ b_i[31];
        prod = '0;
        e    = 0;
        y_o  = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y_o = FP_QNAN;
        end else if (a_inf || b_inf) begin
            y_o = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            y_o = {s, 31'd0};
        end else begin
            prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
            e    = int'(a_i[30:23]) + int'(b_i[30:23]) - 127;
            if (prod[47])
                y_o = fp_round_pack(s, e + 1, prod[47:24], prod[23], |prod[22:0]);
            else
                y_o = fp_round_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
        end
    end

endmodule

// File: rtl/float_exp_dec.sv
// Splits a single-precision value and lowers its exponent by SHIFT,
// clamping at zero (a power-of-two scale-down with exponent floor).
module float_exp_dec #(
    parameter int unsigned SHIFT = 1
) (
    input  logic [31:0] f_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [22:0] man_o
);
    localparam logic [7:0] SH = 8'(SHIFT);

    assign sign_o = f_i[31];
    assign exp_o  = (f_i[30:23] > SH) ? f_i[30:23] - SH : 8'd0;
    assign man_o  = f_i[22:0];

endmodule

// File: rtl/softplus_sequencer.sv
// Softplus ln(1+e^x) ~ ln2 + x/2 + x^2/8 - x^4/192, evaluated over seven
// cycles with one shared multiplier, divider and adder.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// MUL2  | x2 <= x*x
// MUL4  | x4 <= x2*x2
// DIV   | p4 <= x4 / -192
// ADD1  | acc <= ln2 + x/2
// ADD2  | acc <= acc + x2/8
// ADD3  | result <= acc + p4, raise out_valid
// DONE  | hold result until out_ready
module softplus_sequencer
    import softplus_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    if (WIDTH != 32) begin : g_width_check
        $error("softplus_sequencer supports only WIDTH=32");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, x2_q, x2_d, x4_q, x4_d, p4_q, p4_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0] p2, p3, mul_op, mul_y, div_y, add_a, add_b, add_y;

    float_exp_dec #(.SHIFT(1)) u_dec_p2 (
        .f_i    (x_q),
        .sign_o (p2[31]),
        .exp_o  (p2[30:23]),
        .man_o  (p2[22:0])
    );

    float_exp_dec #(.SHIFT(3)) u_dec_p3 (
        .f_i    (x2_q),
        .sign_o (p3[31]),
        .exp_o  (p3[30:23]),
        .man_o  (p3[22:0])
    );

    // Operand steering depends on state only, keeping the unit inputs free of
    // any path through the next-state logic.
    assign mul_op = (state_q == S_MUL2) ? x_q : x2_q;
    assign add_a  = (state_q == S_ADD1) ? LN2 : acc_q;
    assign add_b  = (state_q == S_ADD1) ? p2 :
                    (state_q == S_ADD2) ? p3 : p4_q;

    FloatingMultiplication u_mul (.a_i(mul_op), .b_i(mul_op),  .y_o(mul_y));
    FloatingDivision       u_div (.a_i(x4_q),   .b_i(NEG_192), .y_o(div_y));
    FloatingAddition       u_add (.a_i(add_a),  .b_i(add_b),   .y_o(add_y));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        x2_d        = x2_q;
        x4_d        = x4_q;
        p4_d        = p4_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x_value;
                    state_d = S_MUL2;
                end
            end
            S_MUL2: begin
                x2_d    = mul_y;
                state_d = S_MUL4;
            end
            S_MUL4: begin
                x4_d    = mul_y;
                state_d = S_DIV;
            end
            S_DIV: begin
                p4_d    = div_y;
                state_d = S_ADD1;
            end
            S_ADD1: begin
                acc_d   = add_y;
                state_d = S_ADD2;
            end
            S_ADD2: begin
                acc_d   = add_y;
                state_d = S_ADD3;
            end
            S_ADD3: begin
                result_d    = add_y;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            x2_q        <= '0;
            x4_q        <= '0;
            p4_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            x2_q        <= x2_d;
            x4_q        <= x4_d;
            p4_q        <= p4_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign op_count  = op_count_q;

endmodule
